// File: rtl/ccff_pkg.sv
// Shared types and constants for the CLB configuration-chain loader.
// Holds the loader FSM state type and chain-length defaults.
package ccff_pkg;

  // Each frac_lut4 holds 16 LUT SRAM bits plus 1 mode bit.
  localparam int unsigned FRAC_LUT4_CFG_BITS = 17;
  localparam int unsigned CHAIN_LEN_DEFAULT  = FRAC_LUT4_CFG_BITS;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StShift,
    StDone,
    StErr
  } loader_state_e;

endpackage

// File: rtl/ccff_piso.sv
// Parallel-in / serial-out shifter with a remaining-bit count. MSB leaves first; ser_i enters
// at the LSB, so the same block doubles as a serial-in mirror via par_o.
module ccff_piso #(
  parameter int unsigned Width = 8,
  parameter int unsigned CntW  = $clog2(Width + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [Width-1:0] data_i,
  input  logic [CntW-1:0]  nbits_i,
  input  logic             ser_i,
  output logic             ser_o,
  output logic [Width-1:0] par_o,
  output logic [CntW-1:0]  cnt_o
);

  logic [Width-1:0] sr_q;
  logic [CntW-1:0]  cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sr_q  <= data_i;
      cnt_q <= nbits_i;
    end else if (shift_i) begin
      sr_q  <= {sr_q[Width-2:0], ser_i};
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign ser_o = sr_q[Width-1];
  assign par_o = sr_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises word-wide config data onto a fle configuration chain and gates its prog_clk.
// Optional readback of the previous chain contents via `define CCFF_READBACK_EN.
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_last,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef CCFF_READBACK_EN
  ,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data
`endif
);

  localparam int unsigned NbW = $clog2(WORD_W + 1);

  loader_state_e    state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, bits_left;
  logic             last_q, last_d;
  logic [NbW-1:0]   nbits, piso_cnt;
  logic             load, shift, word_end;
  logic [WORD_W-1:0] unused_par;

  // Final word may be partial: only the bits still owed to the chain are shifted.
  always_comb begin
    bits_left = CNT_W'(CHAIN_LEN) - bit_cnt_q;
    nbits     = (32'(bits_left) >= WORD_W) ? NbW'(WORD_W) : NbW'(bits_left);
  end

  assign word_end = (state_q == StShift) && (piso_cnt <= NbW'(1));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    last_d    = last_q;
    load      = 1'b0;
    shift     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StWait;
      end
      StWait: begin
        if (cfg_valid && cfg_ready) begin
          load    = 1'b1;
          last_d  = cfg_last;
          state_d = StShift;
        end
      end
      StShift: begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (!word_end) begin
          shift = 1'b1;
        end else if (bit_cnt_d == CNT_W'(CHAIN_LEN)) begin
          state_d = last_q ? StDone : StErr;
        end else begin
          state_d = last_q ? StErr : StWait;
        end
      end
      StDone, StErr: begin
        state_d   = StIdle;
        bit_cnt_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      last_q       <= 1'b0;
      cfg_ready    <= 1'b0;
      chain_clk_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      last_q       <= last_d;
      cfg_ready    <= (state_d == StWait);
      chain_clk_en <= (state_d == StShift);
      busy         <= (state_d != StIdle);
      done         <= (state_d == StDone);
      err          <= (state_d == StErr);
    end
  end

  // The last bit of a word is held on ccff_head (no shift) while the FSM moves on.
  ccff_piso #(
    .Width (WORD_W),
    .CntW  (NbW)
  ) u_piso (
    .clk_i   (prog_clk),
    .rst_i   (pReset),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (cfg_data),
    .nbits_i (nbits),
    .ser_i   (1'b0),
    .ser_o   (ccff_head),
    .par_o   (unused_par),
    .cnt_o   (piso_cnt)
  );

`ifdef CCFF_READBACK_EN
  logic [NbW-1:0]    nbits_q;
  logic [WORD_W-1:0] rb_par, rb_word;
  logic              unused_rb_ser;
  logic [NbW-1:0]    unused_rb_cnt;

  // Mirror shifts in lockstep with u_piso; the final tail bit is merged at word end.
  ccff_piso #(
    .Width (WORD_W),
    .CntW  (NbW)
  ) u_rb_mirror (
    .clk_i   (prog_clk),
    .rst_i   (pReset),
    .load_i  (load),
    .shift_i (shift),
    .data_i  ('0),
    .nbits_i (nbits),
    .ser_i   (ccff_tail),
    .ser_o   (unused_rb_ser),
    .par_o   (rb_par),
    .cnt_o   (unused_rb_cnt)
  );

  // Left-justify a partial word so stale bits drop out and the low end is zero.
  assign rb_word = {rb_par[WORD_W-2:0], ccff_tail} << (NbW'(WORD_W) - nbits_q);

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      nbits_q  <= '0;
      rb_valid <= 1'b0;
      rb_data  <= '0;
    end else begin
      if (load) nbits_q <= nbits;
      rb_valid <= word_end;
      if (word_end) rb_data <= rb_word;
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench for ccff_bitstream_loader (WORD_W=8, CHAIN_LEN=17) with a 17-bit chain model.
module tb_ccff_bitstream_loader;

  localparam int unsigned W = 8;
  localparam int unsigned L = 17;

  logic         prog_clk = 1'b0;
  logic         pReset = 1'b1;
  logic         start = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_data = '0;
  logic         cfg_last = 1'b0;
  logic         cfg_ready, ccff_head, chain_clk_en, ccff_tail, busy, done, err;
`ifdef CCFF_READBACK_EN
  logic         rb_valid;
  logic [W-1:0] rb_data;
`endif

  ccff_bitstream_loader #(
    .WORD_W    (W),
    .CHAIN_LEN (L)
  ) dut (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .start        (start),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_data     (cfg_data),
    .cfg_last     (cfg_last),
    .ccff_head    (ccff_head),
    .chain_clk_en (chain_clk_en),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .err          (err)
`ifdef CCFF_READBACK_EN
    ,
    .rb_valid     (rb_valid),
    .rb_data      (rb_data)
`endif
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: DFFR_mem cells on the gated clock, cleared by pReset.
  logic [L-1:0] chain;
  always @(posedge prog_clk or posedge pReset) begin
    if (pReset) chain <= '0;
    else if (chain_clk_en) chain <= {chain[L-2:0], ccff_head};
  end
  assign ccff_tail = chain[L-1];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int en_cnt = 0;
  int tb_bits = 0;
  int ready_viol = 0;
  int acc_cycle = 0;
  bit end_seen = 1'b0;
  logic [L-1:0] snap;
  logic         exp_bits[$];
  logic [1:0]   exp_end[$];
  logic [W-1:0] exp_rb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge prog_clk) cyc++;

  always @(negedge prog_clk) begin
    if (!pReset) begin
      if (end_seen) begin
        check_eq("busy_after_end", busy, 0);
        end_seen = 1'b0;
      end
      if (cfg_ready && chain_clk_en) ready_viol++;
      if (chain_clk_en) begin
        en_cnt++;
        if (exp_bits.size() == 0) check_eq("head_extra_enable", chain_clk_en, 0);
        else check_eq("head_bit", ccff_head, exp_bits.pop_front());
      end
      if (done || err) begin
        if (exp_end.size() == 0) check_eq("spurious_end", {err, done}, 2'b00);
        else check_eq("end_pulse", {err, done}, exp_end.pop_front());
        check_eq("busy_at_end", busy, 1);
        end_seen = 1'b1;
      end
`ifdef CCFF_READBACK_EN
      if (rb_valid) begin
        if (exp_rb.size() == 0) check_eq("spurious_rb", rb_valid, 0);
        else check_eq("rb_data", rb_data, exp_rb.pop_front());
      end
`endif
    end
  end

  // Called and returns on a negedge.
  task automatic do_start();
    en_cnt  = 0;
    tb_bits = 0;
    snap    = chain;
    start   = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("ready_after_start", cfg_ready, 1);
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic l, input bit hold);
    int n, nb;
    logic [W-1:0] rbw;
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = l;
    n = 0;
    while (!cfg_ready && n < 50) begin
      @(negedge prog_clk);
      n++;
    end
    if (!cfg_ready) begin
      check_eq("ready_timeout", cfg_ready, 1);
    end else begin
      acc_cycle = cyc;
      nb  = (L - tb_bits >= W) ? W : L - tb_bits;
      rbw = '0;
      for (int i = 0; i < nb; i++) begin
        exp_bits.push_back(d[W-1-i]);
        rbw[W-1-i] = snap[L-1-(tb_bits+i)];
      end
      exp_rb.push_back(rbw);
      tb_bits += nb;
      if (tb_bits == L && l) exp_end.push_back(2'b01);
      else if (tb_bits == L || l) exp_end.push_back(2'b10);
    end
    @(negedge prog_clk);
    if (!hold) cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(negedge prog_clk);
      n++;
    end
    check_eq({tag, "_idle"}, busy, 0);
    check_eq({tag, "_en_cycles"}, en_cnt, tb_bits);
    check_eq({tag, "_bits_left"}, exp_bits.size(), 0);
    check_eq({tag, "_end_left"}, exp_end.size(), 0);
    repeat (2) @(negedge prog_clk);
  endtask

  initial begin
    int a1;
    #1;
    check_eq("rst_ready", cfg_ready, 0);
    check_eq("rst_head", ccff_head, 0);
    check_eq("rst_en", chain_clk_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    @(negedge prog_clk);
    pReset = 1'b0;
    @(negedge prog_clk);

    // Clean load: 17 bits then done.
    do_start();
    send_word(8'hA5, 0, 0);
    send_word(8'h3C, 0, 0);
    send_word(8'h80, 1, 0);
    wait_idle("clean");
    check_eq("chain_clean", chain, 17'b10100101001111001);

    // Early last after 16 bits.
    do_start();
    send_word(8'hA5, 0, 0);
    send_word(8'h3C, 1, 0);
    wait_idle("early_last");

    // No last at all; third word shifts a single bit.
    do_start();
    send_word(8'hA5, 0, 0);
    send_word(8'h3C, 0, 0);
    send_word(8'h80, 0, 0);
    wait_idle("missing_last");

    // cfg_valid held; start pulsed mid-load.
    do_start();
    send_word(8'h5A, 0, 1);
    a1 = acc_cycle;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    send_word(8'hC3, 0, 1);
    check_eq("accept_interval1", acc_cycle - a1, 9);
    a1 = acc_cycle;
    send_word(8'hFF, 1, 0);
    check_eq("accept_interval2", acc_cycle - a1, 9);
    wait_idle("held_valid");
    check_eq("start_ignored_busy", busy, 0);
    check_eq("start_ignored_ready", cfg_ready, 0);

    // Reset at bit 5 of word 2.
    do_start();
    send_word(8'hA5, 0, 0);
    send_word(8'h3C, 0, 0);
    for (int n = 0; n < 40 && en_cnt < 13; n++) begin
      @(negedge prog_clk);
      #1;
    end
    check_eq("reached_bit13", en_cnt, 13);
    #1 pReset = 1'b1;
    #1;
    check_eq("mid_rst_ready", cfg_ready, 0);
    check_eq("mid_rst_head", ccff_head, 0);
    check_eq("mid_rst_en", chain_clk_en, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_err", err, 0);
    exp_bits.delete();
    exp_end.delete();
    exp_rb.delete();
    end_seen = 1'b0;
    @(negedge prog_clk);
    pReset = 1'b0;
    @(negedge prog_clk);
    do_start();
    send_word(8'hA5, 0, 0);
    send_word(8'h3C, 0, 0);
    send_word(8'h80, 1, 0);
    wait_idle("after_reset");
    check_eq("chain_after_reset", chain, 17'b10100101001111001);

`ifdef CCFF_READBACK_EN
    // Preload all ones, then load zeros and observe the old contents.
    do_start();
    send_word(8'hFF, 0, 0);
    send_word(8'hFF, 0, 0);
    send_word(8'h80, 1, 0);
    wait_idle("preload");
    check_eq("chain_ones", chain, 17'h1FFFF);
    do_start();
    send_word(8'h00, 0, 0);
    send_word(8'h00, 0, 0);
    send_word(8'h00, 1, 0);
    wait_idle("readback");
    check_eq("rb_left", exp_rb.size(), 0);
`endif

    check_eq("ready_never_in_shift", ready_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
